// File: rtl/ov5640_reg_config.sv
// OV5640 register-table sequencer.
// Walks an external register ROM after power-up and issues one 32-bit write per
// entry {DEV_ADDR, reg_addr[15:0], reg_data[7:0]} to the i2c_com engine through
// its start/tr_end/ack handshake. Entries whose reg_addr is 16'hFFFF are delays
// of reg_data*DELAY_UNIT cycles. A NACK or a transfer timeout flags cfg_err.
// Optional feature macro: OV5640_CFG_RETRY_EN (retry a failing entry up to 3 times).
`timescale 1ns/1ps
module ov5640_reg_config #(
  parameter logic [7:0] DEV_ADDR     = 8'h78,
  parameter int         LUT_SIZE     = 256,
  parameter int         PWR_WAIT     = 1024,
  parameter int         GAP_CYCLES   = 2,
  parameter int         XFER_TIMEOUT = 60,
  parameter int         DELAY_UNIT   = 20
) (
  input  logic        clock_i2c,
  input  logic        camera_rst,
  input  logic        cfg_restart,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        start,
  output logic [31:0] i2c_data,
  input  logic        tr_end,
  input  logic        ack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  typedef enum logic [3:0] {
    S_PWR, S_FETCH, S_LOAD, S_DLY, S_XFER, S_CHECK, S_NEXT, S_GAP, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;       // shared cycle counter, zeroed on every state change
  logic [31:0] dly_len, dly_len_nxt;   // length of the current delay entry in cycles
  logic [7:0]  index_nxt;
  logic        start_nxt;
  logic [31:0] data_nxt;
  logic        err_nxt;
  logic        fail, fail_nxt;         // last transfer NACKed or timed out
  logic        gap_load, gap_load_nxt; // after GAP: 1 = re-issue same entry, 0 = fetch next
`ifdef OV5640_CFG_RETRY_EN
  logic [1:0]  retry_cnt, retry_nxt;
`endif

  // Next-state, counter and output decode
  always_comb begin
    state_nxt    = state;
    timer_nxt    = '0;
    dly_len_nxt  = dly_len;
    index_nxt    = lut_index;
    start_nxt    = start;
    data_nxt     = i2c_data;
    err_nxt      = cfg_err;
    fail_nxt     = fail;
    gap_load_nxt = gap_load;
`ifdef OV5640_CFG_RETRY_EN
    retry_nxt    = retry_cnt;
`endif
    case (state)
      S_PWR: begin
        if (timer == 32'(PWR_WAIT - 1)) state_nxt = S_FETCH;
        else                            timer_nxt = timer + 32'd1;
      end
      S_FETCH: begin
        // FETCH is only entered for a new index, so the retry budget restarts here
`ifdef OV5640_CFG_RETRY_EN
        retry_nxt = 2'd0;
`endif
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (lut_data[23:8] == 16'hFFFF) begin
          dly_len_nxt = 32'(lut_data[7:0]) * 32'(DELAY_UNIT);
          state_nxt   = (lut_data[7:0] == 8'd0) ? S_NEXT : S_DLY;
        end else begin
          data_nxt  = {DEV_ADDR, lut_data};
          start_nxt = 1'b1;
          state_nxt = S_XFER;
        end
      end
      S_DLY: begin
        if (timer == dly_len - 32'd1) state_nxt = S_NEXT;
        else                          timer_nxt = timer + 32'd1;
      end
      S_XFER: begin
        // start is dropped on leaving XFER so it is already low during CHECK
        if (tr_end) begin
          fail_nxt  = ack;
          start_nxt = 1'b0;
          state_nxt = S_CHECK;
        end else if (timer == 32'(XFER_TIMEOUT - 1)) begin
          fail_nxt  = 1'b1;
          start_nxt = 1'b0;
          state_nxt = S_CHECK;
        end else begin
          timer_nxt = timer + 32'd1;
        end
      end
      S_CHECK: begin
        if (!fail) begin
          state_nxt = S_NEXT;
        end else begin
`ifdef OV5640_CFG_RETRY_EN
          if (retry_cnt == 2'd3) begin
            err_nxt   = 1'b1;
            state_nxt = S_NEXT;
          end else begin
            retry_nxt    = retry_cnt + 2'd1;
            gap_load_nxt = 1'b1;
            state_nxt    = S_GAP;
          end
`else
          err_nxt   = 1'b1;
          state_nxt = S_NEXT;
`endif
        end
      end
      S_NEXT: begin
        gap_load_nxt = 1'b0;
        if (lut_index == 8'(LUT_SIZE - 1)) begin
          state_nxt = S_DONE;
        end else begin
          index_nxt = lut_index + 8'd1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (timer == 32'(GAP_CYCLES - 1)) state_nxt = gap_load ? S_LOAD : S_FETCH;
        else                              timer_nxt = timer + 32'd1;
      end
      S_DONE: begin
        if (cfg_restart) begin
          err_nxt   = 1'b0;
          index_nxt = 8'd0;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_PWR;
    endcase
  end

  // State and registered outputs; busy/done follow the state being entered
  always_ff @(posedge clock_i2c) begin
    if (camera_rst) begin
      state     <= S_PWR;
      timer     <= '0;
      dly_len   <= '0;
      lut_index <= '0;
      start     <= 1'b0;
      i2c_data  <= '0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      fail      <= 1'b0;
      gap_load  <= 1'b0;
`ifdef OV5640_CFG_RETRY_EN
      retry_cnt <= 2'd0;
`endif
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      dly_len   <= dly_len_nxt;
      lut_index <= index_nxt;
      start     <= start_nxt;
      i2c_data  <= data_nxt;
      cfg_busy  <= (state_nxt != S_DONE);
      cfg_done  <= (state_nxt == S_DONE);
      cfg_err   <= err_nxt;
      fail      <= fail_nxt;
      gap_load  <= gap_load_nxt;
`ifdef OV5640_CFG_RETRY_EN
      retry_cnt <= retry_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ov5640_reg_config.sv
// Bench for ov5640_reg_config: ROM + i2c engine model, transfer monitor and a
// table-level reference model of which writes the walk must produce.
`timescale 1ns/1ps
module tb_ov5640_reg_config;
  localparam int LUT = 3, PWR = 16, GAP = 2, TMO = 12, DUNIT = 4;
`ifdef OV5640_CFG_RETRY_EN
  localparam int TRIES = 4;
`else
  localparam int TRIES = 1;
`endif

  logic        clock_i2c = 1'b0;
  logic        camera_rst = 1'b1;
  logic        cfg_restart = 1'b0;
  logic [7:0]  lut_index;
  logic [23:0] lut_data = 24'h0;
  logic        start;
  logic [31:0] i2c_data;
  logic        tr_end, ack;
  logic        cfg_busy, cfg_done, cfg_err;

  logic        eng_tr = 1'b0, eng_ack = 1'b0, stray = 1'b0;
  logic        nack_en = 1'b0, hang_en = 1'b0;
  logic [15:0] bad_reg = 16'h0;
  int          eng_cnt = 0, eng_lat = 1;
  logic [23:0] rom [256];

  int n_chk = 0, n_pass = 0;

  assign tr_end = eng_tr | stray;
  assign ack    = eng_ack;

  ov5640_reg_config #(
    .DEV_ADDR(8'h78), .LUT_SIZE(LUT), .PWR_WAIT(PWR), .GAP_CYCLES(GAP),
    .XFER_TIMEOUT(TMO), .DELAY_UNIT(DUNIT)
  ) dut (
    .clock_i2c(clock_i2c), .camera_rst(camera_rst), .cfg_restart(cfg_restart),
    .lut_index(lut_index), .lut_data(lut_data), .start(start), .i2c_data(i2c_data),
    .tr_end(tr_end), .ack(ack), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clock_i2c = ~clock_i2c;

  // synchronous ROM, one cycle latency
  always @(posedge clock_i2c) lut_data <= rom[lut_index];

  // engine: random completion latency, NACK or silence for the selected register
  always @(posedge clock_i2c) begin
    if (!start) begin
      eng_tr <= 1'b0; eng_ack <= 1'b0; eng_cnt <= 0;
      eng_lat <= int'($urandom_range(1, 5));
    end else if (!eng_tr) begin
      if (eng_cnt >= eng_lat) begin
        if (!(hang_en && i2c_data[23:8] == bad_reg)) begin
          eng_tr  <= 1'b1;
          eng_ack <= nack_en && (i2c_data[23:8] == bad_reg);
        end
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  // monitor: captured writes, low time before each rise, high time of each transfer
  logic [31:0] cap_q [$];
  int          lo_q [$], hi_q [$];
  int          lo_run = 0, hi_run = 0, stab_err = 0;
  logic        start_d = 1'b0;
  logic [31:0] data_d = 32'h0;
  always @(negedge clock_i2c) begin
    start_d <= start;
    data_d  <= i2c_data;
    if (start && !start_d) begin
      cap_q.push_back(i2c_data);
      lo_q.push_back(lo_run);
      hi_run <= 1;
    end else if (start) begin
      hi_run <= hi_run + 1;
      if (i2c_data !== data_d) stab_err <= stab_err + 1;
    end
    if (!start && start_d) hi_q.push_back(hi_run);
    lo_run <= start ? 0 : lo_run + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] rnd_entry();
    return {16'($urandom_range(0, 16'hFFFE)), 8'($urandom)};
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    while (!cfg_done && n < 3000) begin @(negedge clock_i2c); n++; end
    chk({tag, "_done"}, {31'b0, cfg_done}, 32'd1);
  endtask

  task automatic release_rst(input string tag);
    int n;
    camera_rst = 1'b0;
    @(negedge clock_i2c); n = 1;
    chk({tag, "_pwr_busy"}, {31'b0, cfg_busy}, 32'd1);
    while (!start && n < 200) begin @(negedge clock_i2c); n++; end
    chk({tag, "_pwr_latency"}, 32'(n), 32'(PWR + 2));
  endtask

  task automatic do_restart(input string tag);
    int n;
    cfg_restart = 1'b1;
    @(negedge clock_i2c); cfg_restart = 1'b0; n = 1;
    chk({tag, "_restart_done_clr"}, {31'b0, cfg_done}, 32'd0);
    chk({tag, "_restart_busy"}, {31'b0, cfg_busy}, 32'd1);
    while (!start && n < 50) begin @(negedge clock_i2c); n++; end
    chk({tag, "_restart_latency"}, 32'(n), 32'd3);
  endtask

  // reference: every non-delay entry in order, failing ones repeated TRIES times
  task automatic check_walk(input string tag, input int base);
    logic [31:0] exp_q [$];
    logic        exp_err, bad;
    exp_err = 1'b0;
    for (int i = 0; i < LUT; i++) begin
      if (rom[i][23:8] != 16'hFFFF) begin
        bad = (nack_en | hang_en) & (rom[i][23:8] == bad_reg);
        for (int t = 0; t < (bad ? TRIES : 1); t++) exp_q.push_back({8'h78, rom[i]});
        if (bad) exp_err = 1'b1;
      end
    end
    chk({tag, "_xfer_count"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < cap_q.size()) chk({tag, "_data"}, cap_q[base + k], exp_q[k]);
    for (int k = base + 1; k < cap_q.size(); k++)
      chk({tag, "_gap_min"}, {31'b0, lo_q[k] >= GAP}, 32'd1);
    chk({tag, "_err"}, {31'b0, cfg_err}, {31'b0, exp_err});
    chk({tag, "_busy_idle"}, {31'b0, cfg_busy}, 32'd0);
    chk({tag, "_start_idle"}, {31'b0, start}, 32'd0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    rom[0] = 24'h300882;
    rom[1] = rnd_entry();
    rom[2] = rnd_entry();
    repeat (3) @(negedge clock_i2c);
    chk("rst_start", {31'b0, start}, 32'd0);
    chk("rst_data", i2c_data, 32'd0);
    chk("rst_index", {24'b0, lut_index}, 32'd0);
    chk("rst_busy", {31'b0, cfg_busy}, 32'd0);
    chk("rst_done", {31'b0, cfg_done}, 32'd0);
    chk("rst_err", {31'b0, cfg_err}, 32'd0);

    // plain walk from power-up
    base = cap_q.size();
    release_rst("walk");
    wait_done("walk");
    check_walk("walk", base);
    chk("walk_entry0", cap_q[base], 32'h7830_0882);

    // tr_end outside XFER must not disturb DONE
    stray = 1'b1;
    repeat (4) @(negedge clock_i2c);
    chk("stray_start", {31'b0, start}, 32'd0);
    chk("stray_done", {31'b0, cfg_done}, 32'd1);
    stray = 1'b0;
    @(negedge clock_i2c);

    // delay entry in the middle
    rom[0] = rnd_entry(); rom[1] = 24'hFFFF05; rom[2] = rnd_entry();
    base = cap_q.size();
    do_restart("dly");
    wait_done("dly");
    check_walk("dly", base);
    chk("dly_quiet_min", {31'b0, lo_q[base + 1] >= 5 * DUNIT + GAP}, 32'd1);
    chk("dly_quiet_max", {31'b0, lo_q[base + 1] <= 5 * DUNIT + 2 * GAP + 10}, 32'd1);

    // NACK on entry 1; a restart pulse mid-walk must be ignored
    rom[1] = rnd_entry();
    do rom[0] = rnd_entry(); while (rom[0][23:8] == rom[1][23:8]);
    do rom[2] = rnd_entry(); while (rom[2][23:8] == rom[1][23:8]);
    bad_reg = rom[1][23:8]; nack_en = 1'b1;
    base = cap_q.size();
    do_restart("nack");
    cfg_restart = 1'b1; @(negedge clock_i2c); cfg_restart = 1'b0;
    wait_done("nack");
    check_walk("nack", base);
    nack_en = 1'b0;

    // engine never finishes the last entry -> timeout
    rom[2] = rnd_entry();
    do rom[0] = rnd_entry(); while (rom[0][23:8] == rom[2][23:8]);
    do rom[1] = rnd_entry(); while (rom[1][23:8] == rom[2][23:8]);
    bad_reg = rom[2][23:8]; hang_en = 1'b1;
    base = cap_q.size();
    do_restart("tmo");
    wait_done("tmo");
    check_walk("tmo", base);
    for (int k = base; k < cap_q.size(); k++)
      if (cap_q[k][23:8] == bad_reg) chk("tmo_high_len", 32'(hi_q[k]), 32'(TMO));
    hang_en = 1'b0;

    // reset in the middle of a transfer, then a full walk from power-up
    rom[0] = rnd_entry(); rom[1] = rnd_entry(); rom[2] = rnd_entry();
    do_restart("mid");
    camera_rst = 1'b1;
    @(negedge clock_i2c);
    chk("mid_rst_start", {31'b0, start}, 32'd0);
    chk("mid_rst_index", {24'b0, lut_index}, 32'd0);
    chk("mid_rst_err", {31'b0, cfg_err}, 32'd0);
    @(negedge clock_i2c);
    base = cap_q.size();
    release_rst("mid");
    wait_done("mid");
    check_walk("mid", base);

    chk("data_stable", 32'(stab_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
